// File: rtl/adc_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_fifo
//  Description : Captures finished ADC words on the rising edge of their done
//                strobe, converts them to signed left-aligned samples and
//                buffers them for the equalizer over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_fifo #(
    parameter int IN_W     = 12,
    parameter int OUT_W    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int OFFS_BIN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_done,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam logic [AW:0]   c_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    logic               r_done_d;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_overflow;
    logic [OUT_W-1:0]   r_mem [DEPTH];

    logic [IN_W-1:0]    w_signed;
    logic [OUT_W-1:0]   w_wdata;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    logic               w_full;
    logic               w_wr;
    logic               w_drop;
    logic [AW:0]        w_count_nxt;

    generate
        if (OFFS_BIN != 0) begin : g_offs_bin
            assign w_signed = {~in_data[IN_W-1], in_data[IN_W-2:0]};
        end else begin : g_twos
            assign w_signed = in_data;
        end

        if (OUT_W > IN_W) begin : g_pad
            assign w_wdata = {w_signed, {(OUT_W-IN_W){1'b0}}};
        end else begin : g_nopad
            assign w_wdata = w_signed;
        end
    endgenerate

    assign w_push  = in_done & ~r_done_d;
    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_pop   = w_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_d   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done_d <= in_done;
            r_count  <= w_count_nxt;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    // Storage is never reset, so the head is masked while empty.
    assign out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign out_valid = w_valid;
    assign count     = r_count;
    assign full      = w_full;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_sample_fifo
//  Description : Scoreboard bench for adc_sample_fifo with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sample_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_done;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  count;
    logic        full;
    logic        overflow;
    logic        ovf_clr;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] sb [$];
    logic [15:0] mon_exp;

    adc_sample_fifo #(
        .IN_W(12), .OUT_W(16), .DEPTH(8), .AW(3), .OFFS_BIN(1)
    ) dut (
        .clk(clk), .rst(rst), .in_done(in_done), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] conv(input logic [11:0] w);
        return {~w[11], w[10:0], 4'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer is committed at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pop: got %0h, expected no data at %0t", out_data, $time);
            end else begin
                mon_exp = sb.pop_front();
                check("pop_data", {16'h0, out_data}, {16'h0, mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] w, input logic [15:0] exp, input bit accept,
                        output logic v_before, output logic v_after);
        in_data  = w;
        in_done  = 1'b1;
        v_before = out_valid;
        if (accept) sb.push_back(exp);
        tick();
        in_done = 1'b0;
        v_after = out_valid;
        tick();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (!out_valid) break;
        end
        out_ready = 1'b0;
        check("drain_done_valid", {31'h0, out_valid}, 32'h0);
        check("drain_sb_empty", sb.size(), 32'h0);
    endtask

    logic [11:0] t2_in  [4] = '{12'h000, 12'h800, 12'hFFF, 12'h7FF};
    logic [15:0] t2_exp [4] = '{16'h8000, 16'h0000, 16'h7FF0, 16'hFFF0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic vb, va;
        logic [11:0] w;

        // Reset held with random inputs
        rst = 1'b0; in_done = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_done   = 1'($urandom);
            in_data   = 12'($urandom);
            out_ready = 1'($urandom);
            ovf_clr   = 1'($urandom);
            @(negedge clk);
            check("rst_out_valid", {31'h0, out_valid}, 32'h0);
            check("rst_count",     {28'h0, count},     32'h0);
            check("rst_full",      {31'h0, full},      32'h0);
            check("rst_overflow",  {31'h0, overflow},  32'h0);
            check("rst_out_data",  {16'h0, out_data},  32'h0);
            @(posedge clk);
            #1;
        end
        in_done = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Conversion and one-cycle latency
        for (int i = 0; i < 4; i++) begin
            send(t2_in[i], t2_exp[i], 1'b1, vb, va);
            check("conv_valid_before", {31'h0, vb}, 32'h0);
            check("conv_valid_after",  {31'h0, va}, 32'h1);
            check("conv_head", {16'h0, out_data}, {16'h0, t2_exp[i]});
            drain();
        end

        // Long in_done: exactly one push
        in_data = 12'hA00;
        in_done = 1'b1;
        sb.push_back(16'h2000);
        repeat (5) tick();
        in_done = 1'b0;
        tick();
        check("hold_count", {28'h0, count}, 32'h1);
        check("hold_data", {16'h0, out_data}, 32'h2000);
        drain();

        // Fill past capacity: ninth word dropped
        for (int i = 1; i <= 9; i++) begin
            w = 12'h800 + 12'(i);
            send(w, conv(w), i <= 8, vb, va);
            if (i == 8) begin
                check("fill8_overflow", {31'h0, overflow}, 32'h0);
                check("fill8_full", {31'h0, full}, 32'h1);
            end
        end
        check("ovf_count", {28'h0, count}, 32'h8);
        check("ovf_full", {31'h0, full}, 32'h1);
        check("ovf_flag", {31'h0, overflow}, 32'h1);
        drain();
        check("ovf_sticky", {31'h0, overflow}, 32'h1);
        check("ovf_empty_count", {28'h0, count}, 32'h0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'h0, overflow}, 32'h0);

        // Push and pop together while full, across pointer wrap
        for (int i = 0; i < 3; i++) begin
            w = 12'h100 + 12'(i);
            send(w, conv(w), 1'b1, vb, va);
        end
        drain();
        for (int i = 0; i < 8; i++) begin
            w = 12'h200 + 12'(i);
            send(w, conv(w), 1'b1, vb, va);
        end
        check("wrap_full", {31'h0, full}, 32'h1);
        in_data   = 12'h3AB;
        in_done   = 1'b1;
        out_ready = 1'b1;
        sb.push_back(conv(12'h3AB));
        tick();
        in_done   = 1'b0;
        out_ready = 1'b0;
        check("pp_count", {28'h0, count}, 32'h8);
        check("pp_full", {31'h0, full}, 32'h1);
        check("pp_overflow", {31'h0, overflow}, 32'h0);
        tick();
        drain();

        // Reset mid-stream
        for (int i = 0; i < 5; i++) begin
            w = 12'h400 + 12'(i);
            send(w, conv(w), 1'b1, vb, va);
        end
        check("mid_count5", {28'h0, count}, 32'h5);
        rst = 1'b0;
        #1;
        check("mid_rst_count", {28'h0, count}, 32'h0);
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_data", {16'h0, out_data}, 32'h0);
        sb.delete();
        tick();
        rst = 1'b1;
        tick();
        send(12'h5CD, conv(12'h5CD), 1'b1, vb, va);
        check("post_rst_count", {28'h0, count}, 32'h1);
        check("post_rst_head", {16'h0, out_data}, {16'h0, conv(12'h5CD)});
        drain();

        check("final_sb_empty", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
